// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES encrypt/decrypt core between NUM_REQ requesters.
// One operation in flight; operands held while the core runs; done or timeout ends the wait.
module aes_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_mode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_key,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_error,
    output logic                          aes_start_encryption,
    output logic                          aes_start_decryption,
    output logic [DATA_WIDTH-1:0]         aes_plaintext,
    output logic [DATA_WIDTH-1:0]         aes_cyphertext,
    output logic [DATA_WIDTH-1:0]         aes_key,
    input  logic [DATA_WIDTH-1:0]         aes_enc_result,
    input  logic [DATA_WIDTH-1:0]         aes_dec_result,
    input  logic                          aes_done_enc,
    input  logic                          aes_done_dec,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int IW = GW + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         grant_id_q, grant_id_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         sel;
    logic                  found;
    logic [IW-1:0]         idx_w;

    // Scan requesters starting just after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_w = {1'b0, last_grant_q} + IW'(i) + IW'(1);
            if (idx_w >= IW'(NUM_REQ)) begin
                idx_w = idx_w - IW'(NUM_REQ);
            end
            if (!found && req_valid[idx_w[GW-1:0]]) begin
                found = 1'b1;
                sel   = idx_w[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        last_grant_d         = last_grant_q;
        grant_id_d           = grant_id_q;
        mode_d               = mode_q;
        operand_d            = operand_q;
        key_d                = key_q;
        rsp_data_d           = rsp_data_q;
        rsp_error_d          = rsp_error_q;
        cnt_d                = cnt_q;
        req_ready            = '0;
        rsp_valid            = '0;
        aes_start_encryption = 1'b0;
        aes_start_decryption = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[sel] = 1'b1;
                    operand_d      = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                    key_d          = req_key[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                    mode_d         = req_mode[sel];
                    grant_id_d     = sel;
                    state_d        = START;
                end
            end
            START: begin
                aes_start_encryption = !mode_q;
                aes_start_decryption = mode_q;
                cnt_d                = '0;
                state_d              = WAIT;
            end
            WAIT: begin
                // A done from the other direction is ignored; done beats a same-cycle timeout.
                if (mode_q ? aes_done_dec : aes_done_enc) begin
                    rsp_data_d  = mode_q ? aes_dec_result : aes_enc_result;
                    rsp_error_d = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid[grant_id_q] = 1'b1;
                if (rsp_ready[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer resets to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            mode_q       <= 1'b0;
            operand_q    <= '0;
            key_q        <= '0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            mode_q       <= mode_d;
            operand_q    <= operand_d;
            key_q        <= key_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            cnt_q        <= cnt_d;
        end
    end

    assign aes_plaintext  = operand_q;
    assign aes_cyphertext = operand_q;
    assign aes_key        = key_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_error      = rsp_error_q;
    assign grant_id       = grant_id_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one aes encrypt/decrypt core between NUM_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Holds operands and key stable while the core runs; detects completion by the core's done flags, with a timeout fallback.
- Returns the result and an error flag to the granted requester over a valid/ready response handshake.

Parameters:
- NUM_REQ, 2: number of requesters; range 2..8.
- DATA_WIDTH, 128: width of the block and the key.
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles before the operation is aborted; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept; one-hot or zero.
- req_mode  in  NUM_REQ  per-requester operation select; 0 = encrypt, 1 = decrypt.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester input block; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_key  in  NUM_REQ*DATA_WIDTH  per-requester cipher key; same slicing as req_data.
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_data  out  DATA_WIDTH  result block; shared by all requesters.
- rsp_error  out  1  1 = the operation timed out.
- aes_start_encryption  out  1  start pulse to the core.
- aes_start_decryption  out  1  start pulse to the core.
- aes_plaintext  out  DATA_WIDTH  registered operand to the core.
- aes_cyphertext  out  DATA_WIDTH  registered operand to the core.
- aes_key  out  DATA_WIDTH  registered key to the core.
- aes_enc_result  in  DATA_WIDTH  core encryption output.
- aes_dec_result  in  DATA_WIDTH  core decryption output.
- aes_done_enc  in  1  core encryption done.
- aes_done_dec  in  1  core decryption done.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0; state is IDLE.
  - Operand and key registers are 0; timeout counter is 0.
  - Round-robin pointer is set so that requester 0 has highest priority.
- Reset mid-operation aborts the operation with no response.
- FSM states are IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid is high, select g, the first valid index at or after (last_grant+1) mod NUM_REQ.
  - req_ready[g] is driven combinationally high in the same cycle.
  - Capture req_data[g] into both aes_plaintext and aes_cyphertext, req_key[g] into aes_key, and req_mode[g].
  - Latch g into grant_id and go to START.
  - With no req_valid high, req_ready stays 0.
- START (exactly 1 cycle):
  - Pulse aes_start_encryption if mode = 0, otherwise aes_start_decryption.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - Only the done flag matching the latched mode is honoured; the other done flag is ignored.
  - On the matching done: capture the matching result (aes_enc_result or aes_dec_result) into rsp_data, set rsp_error = 0, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without a matching done: set rsp_data = 0, rsp_error = 1, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[grant_id] = 1; rsp_data and rsp_error are held stable.
  - When rsp_ready[grant_id] is high, clear rsp_valid, set last_grant = grant_id, go to IDLE.
  - rsp_ready on other indices is ignored.
- Operand and key registers hold their values from capture until the next capture, so the combinational key expansion stays stable.
- Minimum cycles per operation: 1 (IDLE) + 1 (START) + core latency + 1 (RESP). A new grant can occur in the cycle after the response is accepted.
- A requester's req_valid deasserting without a grant has no effect. Fairness: a continuously requesting agent waits at most NUM_REQ-1 operations.

Test Plan:
- Encrypt, single requester: reset, then req 0 with mode=0, data=128'h00112233445566778899aabbccddeeff, key=128'h000102030405060708090a0b0c0d0e0f -> req_ready[0] pulses for 1 cycle, one aes_start_encryption pulse, rsp_valid[0] with rsp_data=128'h69c4e0d86a7b0430d8cdb78070b4c55a and rsp_error=0.
- Decrypt round-trip: req 1 with mode=1, data=128'h69c4e0d8...c55a, same key -> rsp_valid[1], rsp_data=128'h00112233...eeff.
- Contention: both req_valid held high for 4 operations -> grant order 0,1,0,1; at most one req_ready and one rsp_valid high in any cycle.
- Backpressure: hold rsp_ready[0] low for 10 cycles -> rsp_valid[0] and rsp_data stay stable; no new grant until rsp_ready[0] is seen high.
- Timeout: core model never asserts done with TIMEOUT_CYCLES=8 -> response arrives 8 cycles after START with rsp_error=1 and rsp_data=0. A wrong-direction done pulse during WAIT is ignored.
- Reset mid-WAIT: drive rst low while in WAIT -> all outputs 0 immediately, no response. After release, requester 0 is granted first.
